bullet_pool: RTL and testbench
==============================

# bullet_pool

Bullet manager that sits directly downstream of the tank controller. It consumes the tank's `ShootBullet` request, its position and the sin/cos of its current angle. It spawns bullets into a fixed pool of slots, moves every live bullet once per frame, reflects them off the arena bounds and retires them on lifetime expiry or collision. Slot positions feed the drawing logic and the collision detector.

## Interface
Parameters:
- `NUM_BULLETS`, 4: pool slots.
- `SPEED`, 4: bullet speed in pixels/frame at full-scale sin/cos.
- `LIFETIME`, 240: frames a bullet lives (8-bit counter).
- `COOLDOWN`, 15: minimum frames between accepted shots (8-bit counter).
- `X_MIN` / `X_MAX`, 0 / 639: arena X bounds, inclusive.
- `Y_MIN` / `Y_MAX`, 0 / 479: arena Y bounds, inclusive.

Ports:
- `frame_clk`  in  1  sole clock; one edge per video frame.
- `Reset`  in  1  synchronous, active-high.
- `game_end`  in  2  nonzero clears the pool and holds it clear.
- `ShootBullet`  in  1  level fire request from the tank.
- `TankX`, `TankY`  in  10 each  tank centre, integer pixels.
- `sin`, `cos`  in  8 each  sign-magnitude; bit 7 is the sign (1 = negative); [6:0] is magnitude, 127 ≈ 1.0.
- `bullet_hit`  in  NUM_BULLETS  per-slot kill from the collision detector.
- `BulletX`, `BulletY`  out  NUM_BULLETS*10 each  integer pixel position; slot i is at [10i+9:10i].
- `BulletActive`  out  NUM_BULLETS  slot live.
- `FirePulse`  out  1  one-cycle pulse when a shot is accepted.

## Operation
Each slot holds the following state:
- `active`.
- `x`, `y`: 14-bit unsigned, 10.4 fixed point.
- `vx`, `vy`: 9-bit signed, in 1/16 px per frame.
- `life`: 8-bit down-counter.

Firing:
- A fire edge is `ShootBullet` high while `shoot_q` (its value in the previous cycle) is low. Holding the button fires once.
- A shot is accepted when there is a fire edge, `cooldown == 0`, `game_end == 0`, and at least one slot was inactive at the start of the cycle.
- On acceptance:
  - The lowest-index free slot loads `x = {TankX,4'b0}` and `y = {TankY,4'b0}`.
  - Velocity: `vx = ±((cos[6:0]*SPEED) >> 3)` and `vy = ∓((sin[6:0]*SPEED) >> 3)`. The sign comes from bit 7. Screen Y grows downward, so positive sin gives negative `vy`.
  - `life` loads `LIFETIME`, `cooldown` loads `COOLDOWN`, and `FirePulse` is 1 for that cycle.
- Rejected fire edges are dropped, not queued.
- `cooldown` decrements by 1 per cycle while it is nonzero.

Motion, per active slot per cycle:
- `nx = x + vx` and `ny = y + vy`, computed 15-bit signed.
- If `nx[14:4]` lies outside [X_MIN, X_MAX], the slot takes the bounds action below and `x` is held. Otherwise `x = nx`. The same applies to Y independently.
- `life` decrements; when `life == 1` the slot goes inactive on this edge.

Retire priority, highest first: `Reset`; `game_end != 0`; `bullet_hit[i]`; lifetime expiry; motion.
- Any retire clears `active` only. `x`, `y`, `vx` and `vy` hold their values.
- A slot retired this cycle is not reusable until the next cycle. The free-slot search uses the pre-edge `active` vector.

Outputs: `BulletX[i] = x[13:4]`, `BulletY[i] = y[13:4]`, `BulletActive[i] = active`.

## Timing
- Reset values:
  - All `active = 0`; all `x`, `y`, `vx`, `vy`, `life` = 0.
  - `cooldown = 0`, `shoot_q = 0`, `FirePulse = 0`.
  - `BulletX`, `BulletY` and `BulletActive` are all 0.
- Fire latency:
  - `ShootBullet` rises before edge n. At edge n the slot becomes active at the tank position, `FirePulse = 1` and `shoot_q` updates.
  - At edge n+1 the slot moves for the first time.
- Because `shoot_q` updates at edge n, a request must be low for at least one sampled edge before it can fire again.
- A bullet is visible for exactly `LIFETIME` edges, from edge n through edge n+LIFETIME-1 inclusive.
- `bullet_hit[i]` sampled at edge k makes `BulletActive[i]` go low after edge k.
- `Reset` or `game_end` takes effect at the next edge, including mid-flight and during cooldown.
- A fire edge arriving in the same cycle as `game_end` is ignored.

## Configuration
`BULLET_BOUNCE_EN`
- Defined: an out-of-bounds axis negates its velocity component (`vx = -vx` or `vy = -vy`) and holds its position. A corner case flips both components.
- Undefined: any out-of-bounds axis retires the slot on that edge. Velocity is untouched.

## Test plan
- Fire with `TankX=300`, `TankY=250`, `cos=0x7F`, `sin=0x00`: slot 0 active at (300,250) with `vx=63` and `FirePulse` high for one cycle. After 16 more frames `BulletX=363`, `BulletY=250`.
- Hold `ShootBullet` for 50 frames: exactly one shot fires. Toggle at 1 frame on, 1 frame off: shots fire only every 15 frames, and never more than 4 are active at once. A fifth edge with the pool full and cooldown at 0 is ignored.
- Lifetime: fire once; `BulletActive[0]` is high for exactly 240 edges, then low. The slot is reused on the next fire.
- Bounce, with the macro defined: fire from (635,250) with `cos=0x7F`. The bullet reaches `nx > 639`, `vx` becomes -63, and the position is held that frame, then decreases. With the macro undefined, the slot retires on that edge.
- Collision: `bullet_hit=4'b0001` in the same cycle as a fire edge with slot 0 active and slot 1 free. Slot 0 clears and slot 1 spawns.
- `game_end=2'b01` with 3 bullets live: all `BulletActive=0` on the next edge. Fires stay ignored until `game_end=0`.

Source files
------------

// File: rtl/bullet_pool.sv
// bullet_pool: fixed pool of bullet slots; spawns on tank fire edges, moves, bounds-checks and retires bullets once per frame.
// Ports: frame_clk/Reset (sync, active-high); game_end clears the pool; ShootBullet, TankX/TankY, sin/cos describe the shot;
//        bullet_hit kills slots; BulletX/BulletY/BulletActive expose slot i at [10i+9:10i] / bit i; FirePulse marks an accepted shot.
// Optional feature: define BULLET_BOUNCE_EN to reflect bullets off the arena bounds instead of retiring them.
module bullet_pool #(
    parameter int NUM_BULLETS = 4,
    parameter int SPEED       = 4,
    parameter int LIFETIME    = 240,
    parameter int COOLDOWN    = 15,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 639,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 479
) (
    input  logic                      frame_clk,
    input  logic                      Reset,
    input  logic [1:0]                game_end,
    input  logic                      ShootBullet,
    input  logic [9:0]                TankX,
    input  logic [9:0]                TankY,
    input  logic [7:0]                sin,
    input  logic [7:0]                cos,
    input  logic [NUM_BULLETS-1:0]    bullet_hit,
    output logic [NUM_BULLETS*10-1:0] BulletX,
    output logic [NUM_BULLETS*10-1:0] BulletY,
    output logic [NUM_BULLETS-1:0]    BulletActive,
    output logic                      FirePulse
);
    localparam int N = NUM_BULLETS;
    logic [N-1:0]  active_q, active_d, ox, oy;
    logic [13:0]   x_q [N], x_d [N], y_q [N], y_d [N];
    logic [8:0]    vx_q [N], vx_d [N], vy_q [N], vy_d [N];
    logic [7:0]    life_q [N], life_d [N];
    logic [7:0]    cooldown_q, cooldown_d;
    logic          shoot_q, shoot_d, fire_q, fire_d;
    logic          accept, taken, spawn;
    logic [14:0]   nx [N], ny [N];
    logic [15:0]   cprod, sprod;
    logic [8:0]    cmag, smag, vx_new, vy_new;
    always_comb begin
        cprod      = 16'(cos[6:0]) * 16'(SPEED);
        sprod      = 16'(sin[6:0]) * 16'(SPEED);
        cmag       = 9'(cprod >> 3);
        smag       = 9'(sprod >> 3);
        vx_new     = cos[7] ? -cmag : cmag;
        // screen Y grows downward, so positive sin moves up
        vy_new     = sin[7] ? smag : -smag;
        accept     = ShootBullet && !shoot_q && cooldown_q == 8'd0 && game_end == 2'd0 && !(&active_q);
        cooldown_d = accept ? 8'(COOLDOWN) : (cooldown_q != 8'd0) ? cooldown_q - 8'd1 : cooldown_q;
        shoot_d    = ShootBullet;
        fire_d     = accept;
        taken      = 1'b0;
        spawn      = 1'b0;
        for (int i = 0; i < N; i++) begin
            nx[i]       = {1'b0, x_q[i]} + {{6{vx_q[i][8]}}, vx_q[i]};
            ny[i]       = {1'b0, y_q[i]} + {{6{vy_q[i][8]}}, vy_q[i]};
            ox[i]       = $signed(nx[i][14:4]) < $signed(11'(X_MIN)) || $signed(nx[i][14:4]) > $signed(11'(X_MAX));
            oy[i]       = $signed(ny[i][14:4]) < $signed(11'(Y_MIN)) || $signed(ny[i][14:4]) > $signed(11'(Y_MAX));
            active_d[i] = active_q[i];
            x_d[i]      = x_q[i];
            y_d[i]      = y_q[i];
            vx_d[i]     = vx_q[i];
            vy_d[i]     = vy_q[i];
            life_d[i]   = life_q[i];
            // lowest free slot in the pre-edge active vector takes the shot
            spawn       = accept && !active_q[i] && !taken;
            taken       = taken || !active_q[i];
            if (game_end != 2'd0) begin
                active_d[i] = 1'b0;
            end else if (spawn) begin
                active_d[i] = 1'b1;
                x_d[i]      = {TankX, 4'b0};
                y_d[i]      = {TankY, 4'b0};
                vx_d[i]     = vx_new;
                vy_d[i]     = vy_new;
                life_d[i]   = 8'(LIFETIME);
            end else if (active_q[i]) begin
                if (bullet_hit[i] || life_q[i] == 8'd1) begin
                    active_d[i] = 1'b0;
`ifdef BULLET_BOUNCE_EN
                end else begin
                    x_d[i]    = ox[i] ? x_q[i] : nx[i][13:0];
                    y_d[i]    = oy[i] ? y_q[i] : ny[i][13:0];
                    vx_d[i]   = ox[i] ? -vx_q[i] : vx_q[i];
                    vy_d[i]   = oy[i] ? -vy_q[i] : vy_q[i];
                    life_d[i] = life_q[i] - 8'd1;
                end
`else
                end else if (ox[i] || oy[i]) begin
                    active_d[i] = 1'b0;
                end else begin
                    x_d[i]    = nx[i][13:0];
                    y_d[i]    = ny[i][13:0];
                    life_d[i] = life_q[i] - 8'd1;
                end
`endif
            end
        end
    end
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            active_q   <= '0;
            cooldown_q <= '0;
            shoot_q    <= 1'b0;
            fire_q     <= 1'b0;
            for (int i = 0; i < N; i++) begin
                x_q[i]    <= '0;
                y_q[i]    <= '0;
                vx_q[i]   <= '0;
                vy_q[i]   <= '0;
                life_q[i] <= '0;
            end
        end else begin
            active_q   <= active_d;
            cooldown_q <= cooldown_d;
            shoot_q    <= shoot_d;
            fire_q     <= fire_d;
            for (int i = 0; i < N; i++) begin
                x_q[i]    <= x_d[i];
                y_q[i]    <= y_d[i];
                vx_q[i]   <= vx_d[i];
                vy_q[i]   <= vy_d[i];
                life_q[i] <= life_d[i];
            end
        end
    end
    for (genvar g = 0; g < N; g++) begin : g_out
        assign BulletX[10*g +: 10] = x_q[g][13:4];
        assign BulletY[10*g +: 10] = y_q[g][13:4];
    end
    assign BulletActive = active_q;
    assign FirePulse    = fire_q;
endmodule

// File: tb/tb_bullet_pool.sv
// tb_bullet_pool: randomized and directed checks of bullet_pool against a frame-level integer model.
module tb_bullet_pool;
    localparam int N = 4, SPEED = 4, LIFETIME = 240, COOLDOWN = 15;
    localparam int X_MIN = 0, X_MAX = 639, Y_MIN = 0, Y_MAX = 479;
    logic             frame_clk = 1'b0;
    logic             Reset = 1'b0;
    logic [1:0]       game_end = 2'd0;
    logic             ShootBullet = 1'b0;
    logic [9:0]       TankX = '0, TankY = '0;
    logic [7:0]       sin = '0, cos = '0;
    logic [N-1:0]     bullet_hit = '0;
    logic [N*10-1:0]  BulletX, BulletY;
    logic [N-1:0]     BulletActive;
    logic             FirePulse;
    int checks = 0, errors = 0;
    int m_a [N], m_x [N], m_y [N], m_vx [N], m_vy [N], m_life [N];
    int m_cd, m_shoot;
    logic m_fire;
    logic [N-1:0] m_act;
    logic [N*10-1:0] m_bx, m_by;

    bullet_pool #(.NUM_BULLETS(N), .SPEED(SPEED), .LIFETIME(LIFETIME), .COOLDOWN(COOLDOWN),
                  .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX)) dut (
        .frame_clk(frame_clk), .Reset(Reset), .game_end(game_end), .ShootBullet(ShootBullet),
        .TankX(TankX), .TankY(TankY), .sin(sin), .cos(cos), .bullet_hit(bullet_hit),
        .BulletX(BulletX), .BulletY(BulletY), .BulletActive(BulletActive), .FirePulse(FirePulse));

    always #5 frame_clk = ~frame_clk;

    // One frame of game rules, evaluated on the inputs present at the coming edge.
    task automatic model_step();
        int free = -1;
        int nx, ny, cm, sm;
        bit acc, outx, outy;
        for (int i = 0; i < N; i++) if (m_a[i] == 0 && free < 0) free = i;
        acc = ShootBullet && m_shoot == 0 && m_cd == 0 && game_end == 0 && free >= 0;
        cm = int'(cos[6:0]) * SPEED / 8;
        sm = int'(sin[6:0]) * SPEED / 8;
        if (Reset) begin
            for (int i = 0; i < N; i++) begin
                m_a[i] = 0; m_x[i] = 0; m_y[i] = 0; m_vx[i] = 0; m_vy[i] = 0; m_life[i] = 0;
            end
            m_cd = 0; m_shoot = 0; m_fire = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                nx = m_x[i] + m_vx[i];
                ny = m_y[i] + m_vy[i];
                outx = nx < X_MIN * 16 || nx >= (X_MAX + 1) * 16;
                outy = ny < Y_MIN * 16 || ny >= (Y_MAX + 1) * 16;
                if (game_end != 0) m_a[i] = 0;
                else if (acc && i == free) begin
                    m_a[i] = 1; m_x[i] = int'(TankX) * 16; m_y[i] = int'(TankY) * 16;
                    m_vx[i] = cos[7] ? -cm : cm; m_vy[i] = sin[7] ? sm : -sm; m_life[i] = LIFETIME;
                end else if (m_a[i] != 0) begin
                    if (bullet_hit[i] || m_life[i] == 1) m_a[i] = 0;
                    else begin
`ifdef BULLET_BOUNCE_EN
                        if (outx) m_vx[i] = -m_vx[i]; else m_x[i] = nx;
                        if (outy) m_vy[i] = -m_vy[i]; else m_y[i] = ny;
                        m_life[i]--;
`else
                        if (outx || outy) m_a[i] = 0;
                        else begin m_x[i] = nx; m_y[i] = ny; m_life[i]--; end
`endif
                    end
                end
            end
            m_cd = acc ? COOLDOWN : (m_cd > 0 ? m_cd - 1 : 0);
            m_shoot = int'(ShootBullet);
            m_fire = acc;
        end
        for (int i = 0; i < N; i++) begin
            m_act[i] = m_a[i] != 0;
            m_bx[10*i +: 10] = 10'(m_x[i] / 16);
            m_by[10*i +: 10] = 10'(m_y[i] / 16);
        end
    endtask

    task automatic step();
        model_step();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic do_reset();
        ShootBullet = 0; game_end = 0; bullet_hit = '0; Reset = 1;
        step();
        Reset = 0;
    endtask

    task automatic test_reset();
        TankX = 10'd123; TankY = 10'd45; cos = 8'h55; sin = 8'hAA;
        ShootBullet = 1; Reset = 1;
        step(); step();
        Reset = 0; ShootBullet = 0;
        checks++;
        if ({BulletActive, FirePulse} !== '0) begin errors++; $display("FAIL reset_active act=%b fire=%b want 0", BulletActive, FirePulse); end
        checks++;
        if ({BulletX, BulletY} !== '0) begin errors++; $display("FAIL reset_pos x=%h y=%h want 0", BulletX, BulletY); end
    endtask

    task automatic test_first_shot();
        do_reset();
        TankX = 10'd300; TankY = 10'd250; cos = 8'h7F; sin = 8'h00; ShootBullet = 1;
        step();
        checks++;
        if (FirePulse !== 1'b1) begin errors++; $display("FAIL first_pulse got=%b want 1", FirePulse); end
        checks++;
        if (BulletActive !== 4'b0001) begin errors++; $display("FAIL first_slot got=%b want 0001", BulletActive); end
        checks++;
        if (BulletX[9:0] !== 10'd300 || BulletY[9:0] !== 10'd250) begin errors++; $display("FAIL first_pos got=(%0d,%0d) want (300,250)", BulletX[9:0], BulletY[9:0]); end
        ShootBullet = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            checks++;
            if ({BulletActive, BulletX, BulletY, FirePulse} !== {m_act, m_bx, m_by, m_fire}) begin
                errors++; $display("FAIL first_model k=%0d dut=%h model=%h", k, {BulletActive, BulletX, BulletY, FirePulse}, {m_act, m_bx, m_by, m_fire});
            end
            if (k == 0) begin
                checks++;
                if (FirePulse !== 1'b0) begin errors++; $display("FAIL first_pulse_len got=%b want 0", FirePulse); end
            end
        end
        checks++;
        if (BulletX[9:0] !== 10'd363 || BulletY[9:0] !== 10'd250) begin errors++; $display("FAIL first_motion got=(%0d,%0d) want (363,250)", BulletX[9:0], BulletY[9:0]); end
    endtask

    task automatic test_hold();
        int fires = 0;
        do_reset();
        TankX = 10'd320; TankY = 10'd240; cos = 8'h00; sin = 8'h00; ShootBullet = 1;
        for (int k = 0; k < 50; k++) begin
            step();
            fires += int'(FirePulse);
            checks++;
            if ({BulletActive, BulletX, BulletY, FirePulse} !== {m_act, m_bx, m_by, m_fire}) begin
                errors++; $display("FAIL hold_model k=%0d dut=%h model=%h", k, {BulletActive, BulletX, BulletY, FirePulse}, {m_act, m_bx, m_by, m_fire});
            end
        end
        ShootBullet = 0;
        checks++;
        if (fires != 1) begin errors++; $display("FAIL hold_count got=%0d want 1", fires); end
    endtask

    task automatic test_toggle();
        int fires = 0, last = -100;
        do_reset();
        TankX = 10'd320; TankY = 10'd240;
        for (int k = 0; k < 120; k++) begin
            cos = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 31))};
            sin = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 31))};
            ShootBullet = (k % 2 == 0);
            step();
            checks++;
            if ({BulletActive, BulletX, BulletY, FirePulse} !== {m_act, m_bx, m_by, m_fire}) begin
                errors++; $display("FAIL toggle_model k=%0d dut=%h model=%h", k, {BulletActive, BulletX, BulletY, FirePulse}, {m_act, m_bx, m_by, m_fire});
            end
            if (FirePulse === 1'b1) begin
                checks++;
                if (k - last < COOLDOWN + 1) begin errors++; $display("FAIL toggle_spacing gap=%0d want >=%0d", k - last, COOLDOWN + 1); end
                last = k;
                fires++;
            end
            if (k == 64) begin
                checks++;
                if (BulletActive !== 4'b1111 || FirePulse !== 1'b0) begin errors++; $display("FAIL toggle_full act=%b fire=%b want 1111/0", BulletActive, FirePulse); end
            end
        end
        ShootBullet = 0;
        checks++;
        if (fires != 4) begin errors++; $display("FAIL toggle_count got=%0d want 4", fires); end
    endtask

    task automatic test_lifetime();
        int lit = 1;
        do_reset();
        TankX = 10'd100; TankY = 10'd100; cos = 8'h00; sin = 8'h00; ShootBullet = 1;
        step();
        ShootBullet = 0;
        for (int k = 0; k < 300; k++) begin
            step();
            if (BulletActive[0] === 1'b1) lit++;
            checks++;
            if ({BulletActive, BulletX, BulletY, FirePulse} !== {m_act, m_bx, m_by, m_fire}) begin
                errors++; $display("FAIL life_model k=%0d dut=%h model=%h", k, {BulletActive, BulletX, BulletY, FirePulse}, {m_act, m_bx, m_by, m_fire});
            end
        end
        checks++;
        if (lit != LIFETIME) begin errors++; $display("FAIL life_len got=%0d want %0d", lit, LIFETIME); end
        TankX = 10'd200;
        ShootBullet = 1;
        step();
        ShootBullet = 0;
        checks++;
        if (BulletActive !== 4'b0001 || FirePulse !== 1'b1 || BulletX[9:0] !== 10'd200) begin
            errors++; $display("FAIL life_reuse act=%b fire=%b x=%0d want 0001/1/200", BulletActive, FirePulse, BulletX[9:0]);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        TankX = 10'd635; TankY = 10'd250; cos = 8'h7F; sin = 8'h00; ShootBullet = 1;
        step();
        ShootBullet = 0;
        step();
        checks++;
        if (BulletX[9:0] !== 10'd638) begin errors++; $display("FAIL bounce_pre got=%0d want 638", BulletX[9:0]); end
        step();
`ifdef BULLET_BOUNCE_EN
        checks++;
        if (BulletActive[0] !== 1'b1 || BulletX[9:0] !== 10'd638) begin errors++; $display("FAIL bounce_hold act=%b x=%0d want 1/638", BulletActive[0], BulletX[9:0]); end
        step();
        checks++;
        if (BulletX[9:0] !== 10'd635) begin errors++; $display("FAIL bounce_back got=%0d want 635", BulletX[9:0]); end
`else
        checks++;
        if (BulletActive[0] !== 1'b0) begin errors++; $display("FAIL bounds_retire got=%b want 0", BulletActive[0]); end
`endif
        checks++;
        if ({BulletActive, BulletX, BulletY, FirePulse} !== {m_act, m_bx, m_by, m_fire}) begin
            errors++; $display("FAIL bounce_model dut=%h model=%h", {BulletActive, BulletX, BulletY, FirePulse}, {m_act, m_bx, m_by, m_fire});
        end
    endtask

    task automatic test_collision();
        do_reset();
        TankX = 10'd100; TankY = 10'd100; cos = 8'h00; sin = 8'h00; ShootBullet = 1;
        step();
        ShootBullet = 0;
        for (int k = 0; k < 16; k++) step();
        bullet_hit = 4'b0001; ShootBullet = 1; TankX = 10'd50;
        step();
        bullet_hit = '0; ShootBullet = 0;
        checks++;
        if (BulletActive !== 4'b0010 || FirePulse !== 1'b1) begin errors++; $display("FAIL hit_spawn act=%b fire=%b want 0010/1", BulletActive, FirePulse); end
        checks++;
        if (BulletX[19:10] !== 10'd50 || BulletX[9:0] !== 10'd100) begin errors++; $display("FAIL hit_pos s1=%0d s0=%0d want 50/100", BulletX[19:10], BulletX[9:0]); end
    endtask

    task automatic test_game_end();
        int fires = 0;
        do_reset();
        TankX = 10'd300; TankY = 10'd200; cos = 8'h00; sin = 8'h00;
        for (int s = 0; s < 3; s++) begin
            ShootBullet = 1; step(); ShootBullet = 0;
            for (int k = 0; k < 16; k++) step();
        end
        checks++;
        if (BulletActive !== 4'b0111) begin errors++; $display("FAIL ge_setup got=%b want 0111", BulletActive); end
        game_end = 2'b01;
        step();
        checks++;
        if (BulletActive !== 4'b0000) begin errors++; $display("FAIL ge_clear got=%b want 0000", BulletActive); end
        for (int k = 0; k < 40; k++) begin
            ShootBullet = (k % 2 == 0);
            game_end = 2'($urandom_range(1, 3));
            step();
            fires += int'(FirePulse);
            checks++;
            if ({BulletActive, BulletX, BulletY, FirePulse} !== {m_act, m_bx, m_by, m_fire}) begin
                errors++; $display("FAIL ge_model k=%0d dut=%h model=%h", k, {BulletActive, BulletX, BulletY, FirePulse}, {m_act, m_bx, m_by, m_fire});
            end
        end
        checks++;
        if (fires != 0) begin errors++; $display("FAIL ge_fires got=%0d want 0", fires); end
        game_end = 0; ShootBullet = 0;
        step();
        ShootBullet = 1;
        step();
        ShootBullet = 0;
        checks++;
        if (BulletActive !== 4'b0001 || FirePulse !== 1'b1) begin errors++; $display("FAIL ge_resume act=%b fire=%b want 0001/1", BulletActive, FirePulse); end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            Reset = ($urandom_range(0, 799) == 0);
            game_end = ($urandom_range(0, 149) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            ShootBullet = ($urandom_range(0, 2) != 0);
            TankX = 10'($urandom_range(0, 700));
            TankY = 10'($urandom_range(0, 520));
            sin = 8'($urandom);
            cos = 8'($urandom);
            for (int i = 0; i < N; i++) bullet_hit[i] = ($urandom_range(0, 39) == 0);
            step();
            checks++;
            if ({BulletActive, BulletX, BulletY, FirePulse} !== {m_act, m_bx, m_by, m_fire}) begin
                errors++; $display("FAIL rand_model k=%0d dut=%h model=%h", k, {BulletActive, BulletX, BulletY, FirePulse}, {m_act, m_bx, m_by, m_fire});
            end
        end
        Reset = 0; game_end = 0; ShootBullet = 0; bullet_hit = '0;
    endtask

    initial begin
        test_reset();
        test_first_shot();
        test_hold();
        test_toggle();
        test_lifetime();
        test_bounce();
        test_collision();
        test_game_end();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
